// File: rtl/sqrt_stream_if.sv
// sqrt_stream_if: valid/ready wrapper around the structural square-root core.
// Accepts one 8-bit operand at a time, runs the core once per operand and
// queues the 4-bit results in a small circular FIFO toward the consumer.
// Optional watchdog: define SQRT_IF_TIMEOUT_EN to add the TIMEOUT_CYC
// counter and the err_o pulse output.
module sqrt_stream_if #(
   parameter int unsigned OUT_DEPTH = 2
`ifdef SQRT_IF_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 200
`endif
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [7:0] in_data_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [3:0] out_data_o,
   output logic       core_enb_o,
   output logic [7:0] core_x_o,
   input  logic       core_busy_i,
   input  logic [3:0] core_r_i
`ifdef SQRT_IF_TIMEOUT_EN
   ,output logic      err_o
`endif
);

   localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

   typedef enum logic [1:0] {S_WAKE, S_IDLE, S_LAUNCH, S_RUN} state_t;

   state_t          r_state;
   logic [7:0]      r_x;
   logic [3:0]      r_mem [OUT_DEPTH];
   logic [PW-1:0]   r_wr;
   logic [PW-1:0]   r_rd;
   logic [CW-1:0]   r_cnt;

   logic            w_ready;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic            w_active;
   logic            w_timeout;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_active = (r_state == S_LAUNCH) || (r_state == S_RUN);
   assign w_ready  = (r_state == S_IDLE) && (r_cnt < CW'(OUT_DEPTH));
   assign w_accept = w_ready && in_valid_i;
   assign w_pop    = (r_cnt != '0) && out_ready_i;
   assign w_push   = (r_state == S_RUN) && !core_busy_i && !w_timeout;

   // Enable follows busy in RUN so the core sees it low the cycle it goes idle.
   assign core_enb_o = !w_timeout &&
                       ((r_state == S_LAUNCH) || ((r_state == S_RUN) && core_busy_i));

   assign in_ready_o  = w_ready;
   assign out_valid_o = (r_cnt != '0);
   assign out_data_o  = r_mem[r_rd];
   assign core_x_o    = r_x;

`ifdef SQRT_IF_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [TW-1:0] r_tcnt;
   logic          r_err;

   assign w_timeout = w_active && (r_tcnt == TW'(TIMEOUT_CYC));
   assign err_o     = r_err;

   // Watchdog: cycles spent in LAUNCH/RUN for the current operand.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_tcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept)      r_tcnt <= '0;
         else if (w_active) r_tcnt <= r_tcnt + TW'(1);
         r_err <= w_timeout;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Controller: one operand in flight, core run sequencing.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_WAKE;
         r_x     <= '0;
      end else begin
         case (r_state)
            S_WAKE:   if (!core_busy_i) r_state <= S_IDLE;
            S_IDLE: begin
               if (w_accept) begin
                  r_x     <= in_data_i;
                  r_state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (w_timeout)       r_state <= S_WAKE;
               else if (core_busy_i) r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_timeout)        r_state <= S_WAKE;
               else if (!core_busy_i) r_state <= S_IDLE;
            end
            default:  r_state <= S_WAKE;
         endcase
      end
   end

   // Result FIFO: circular buffer with occupancy counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= core_r_i;
            r_wr        <= f_next(r_wr);
         end
         if (w_pop) r_rd <= f_next(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_stream_if.sv
// Directed bench for sqrt_stream_if with a behavioural square-root core model.
module tb_sqrt_stream_if;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       core_enb;
   logic [7:0] core_x;
   logic       core_busy;
   logic [3:0] core_r;
`ifdef SQRT_IF_TIMEOUT_EN
   logic       err;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int q[$];
   bit hold = 1'b0;
   logic prev_busy = 1'b1;

   always #5 clk = ~clk;

   sqrt_stream_if dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .core_enb_o  (core_enb),
      .core_x_o    (core_x),
      .core_busy_i (core_busy),
      .core_r_i    (core_r)
`ifdef SQRT_IF_TIMEOUT_EN
      ,.err_o      (err)
`endif
   );

   function automatic int isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   // Core model: busy after reset, enable low forces idle, fixed-latency run.
   int         c_cnt;
   logic [7:0] c_x;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         core_busy <= 1'b1;
         core_r    <= '0;
         c_cnt     <= 0;
         c_x       <= '0;
      end else if (!core_enb) begin
         core_busy <= 1'b0;
         c_cnt     <= 0;
      end else if (!core_busy) begin
         core_busy <= 1'b1;
         c_x       <= core_x;
         c_cnt     <= 6 * (isqrt(int'(core_x)) + 1) + 2;
      end else if (c_cnt == 0) begin
         if (!hold) begin
            core_busy <= 1'b0;
            core_r    <= 4'(isqrt(int'(c_x)));
         end
      end else begin
         c_cnt <= c_cnt - 1;
      end
   end

   // Output beat collector.
   always @(posedge clk) begin
      if (rstn && out_valid && out_ready) q.push_back(int'(out_data));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Enable must already be low on the first cycle busy is low.
   always @(negedge clk) begin
      if (rstn && prev_busy && !core_busy) chk("enb_low_on_busy_fall", 32'(core_enb), 32'd0);
      prev_busy = core_busy;
   end

   task automatic send(input logic [7:0] x);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = x;
      for (int i = 0; i < 1000; i++) begin
         if (in_ready) begin
            @(negedge clk);
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("accept", 32'(acc), 32'd1);
      chk("core_x", 32'(core_x), 32'(x));
   endtask

   task automatic wait_out(input int n);
      int i = 0;
      while (q.size() < n && i < 1000) begin
         @(negedge clk);
         i++;
      end
      repeat (20) @(negedge clk);
      chk("beat_count", 32'(q.size()), 32'(n));
   endtask

   function automatic logic [31:0] qat(input int k);
      return (k < q.size()) ? 32'(q[k]) : 32'hDEAD;
   endfunction

   initial begin
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_core_enb",  32'(core_enb),  32'd0);
      chk("rst_core_x",    32'(core_x),    32'd0);
`ifdef SQRT_IF_TIMEOUT_EN
      chk("rst_err",       32'(err),       32'd0);
`endif

      // Release: core busy for one cycle, then IDLE
      rstn = 1'b1;
      @(negedge clk);
      chk("wake_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("idle_in_ready",  32'(in_ready),  32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Single operand
      q.delete();
      send(8'd16);
      wait_out(1);
      chk("sqrt16", qat(0), 32'd4);

      // Back-to-back stream
      q.delete();
      send(8'd0);
      send(8'd1);
      send(8'd255);
      send(8'd200);
      send(8'd99);
      wait_out(5);
      chk("stream0", qat(0), 32'd0);
      chk("stream1", qat(1), 32'd1);
      chk("stream2", qat(2), 32'd15);
      chk("stream3", qat(3), 32'd14);
      chk("stream4", qat(4), 32'd9);

      // Backpressure: two results buffered, third operand refused
      q.delete();
      out_ready = 1'b0;
      send(8'd9);
      send(8'd25);
      in_valid = 1'b1;
      in_data  = 8'd36;
      repeat (150) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  32'(out_data),  32'd3);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_core_x",    32'(core_x),    32'd25);
      chk("bp_no_beats",  32'(q.size()),  32'd0);
      out_ready = 1'b1;
      send(8'd36);
      wait_out(3);
      chk("bp0", qat(0), 32'd3);
      chk("bp1", qat(1), 32'd5);
      chk("bp2", qat(2), 32'd6);

      // Reset during RUN discards the operand
      q.delete();
      send(8'd144);
      repeat (20) @(negedge clk);
      chk("run_busy", 32'(core_busy), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
      chk("mid_rst_core_x",    32'(core_x),    32'd0);
      chk("mid_rst_core_enb",  32'(core_enb),  32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (150) @(negedge clk);
      chk("no_144_result", 32'(q.size()), 32'd0);
      send(8'd4);
      wait_out(1);
      chk("sqrt4", qat(0), 32'd2);

`ifdef SQRT_IF_TIMEOUT_EN
      // Watchdog: core never finishes
      begin
         int n = 0;
         q.delete();
         hold = 1'b1;
         send(8'd81);
         for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
               n = i;
               break;
            end
         end
         chk("err_cycle", 32'(n), 32'd201);
         @(negedge clk);
         chk("err_one_cycle", 32'(err), 32'd0);
         hold = 1'b0;
         repeat (5) @(negedge clk);
         chk("to_no_push", 32'(q.size()), 32'd0);
         send(8'd49);
         wait_out(1);
         chk("sqrt49", qat(0), 32'd7);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
